// File: rtl/dct_transpose_buffer.sv
// -----------------------------------------------------------------------------
// dct_transpose_buffer
//
// Ping-pong 8x8 transpose memory between the row pass and the column pass of
// a 2-D DCT. Coefficients arrive in row-major order and leave in column-major
// order. There are two banks, so one block can fill while the previous block
// drains. This sustains one coefficient per cycle in each direction.
//
// Ports
//   clk        single clock, all state changes on the rising edge
//   reset      synchronous, active-high; clears storage, flags and pointers
//   in_valid   in_data holds a coefficient
//   in_ready   buffer accepts a coefficient this cycle
//   in_data    N-bit coefficient, element k = row k[5:3], column k[2:0]
//   out_valid  out_data holds a coefficient
//   out_ready  downstream takes out_data this cycle
//   out_data   N-bit coefficient, column-major order
//   out_first  marks output index 0 of a block
//   out_last   marks output index 63 of a block
//
// Handshake rule, same on both sides: a transfer happens on a rising edge
// where valid and ready are both high. A producer that is holding valid while
// ready is low keeps its data and flags unchanged until the transfer happens.
// -----------------------------------------------------------------------------
module dct_transpose_buffer #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_first,
  output logic         out_last
);

  logic [N-1:0] r_mem [2][64];
  logic [1:0]   r_full;
  logic         r_wb;
  logic         r_rb;
  logic [5:0]   r_wi;
  logic [5:0]   r_ri;

  logic         w_accept;
  logic         w_handshake;
  logic         w_valid;
  logic [5:0]   w_rd_addr;

  // Output index ri reads row ri[2:0] and column ri[5:3]. The row-major storage
  // address is therefore the two halves of ri swapped.
  assign w_rd_addr = {r_ri[2:0], r_ri[5:3]};

  // Both handshake outputs are gated by reset. This keeps them quiet during
  // the reset cycle itself, before the flags have been cleared.
  assign w_valid     = !reset && r_full[r_rb];
  assign in_ready    = !reset && !r_full[r_wb];
  assign w_accept    = in_valid && in_ready;
  assign w_handshake = w_valid && out_ready;

  assign out_valid = w_valid;
  assign out_data  = w_valid ? r_mem[r_rb][w_rd_addr] : '0;
  assign out_first = w_valid && (r_ri == 6'd0);
  assign out_last  = w_valid && (r_ri == 6'd63);

  // Coefficient storage. Only the bank being written can change.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 64; i++) begin
          r_mem[b][i] <= '0;
        end
      end
    end else if (w_accept) begin
      r_mem[r_wb][r_wi] <= in_data;
    end
  end

  // Pointers and full flags. A full flag is set only by the write side on
  // bank wb and cleared only by the read side on bank rb. When both events
  // happen on the same edge, they always target different banks. That makes
  // the two updates below independent.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_full <= 2'b00;
      r_wb   <= 1'b0;
      r_rb   <= 1'b0;
      r_wi   <= 6'd0;
      r_ri   <= 6'd0;
    end else begin
      if (w_accept) begin
        r_wi <= r_wi + 6'd1;
        if (r_wi == 6'd63) begin
          r_full[r_wb] <= 1'b1;
          r_wb         <= !r_wb;
        end
      end
      if (w_handshake) begin
        r_ri <= r_ri + 6'd1;
        if (r_ri == 6'd63) begin
          r_full[r_rb] <= 1'b0;
          r_rb         <= !r_rb;
        end
      end
    end
  end

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// -----------------------------------------------------------------------------
// tb_dct_transpose_buffer
//
// Directed bench for the ping-pong transpose buffer. A cycle table checks
// single-block behaviour. Hand-written sequences cover streaming,
// backpressure, stall stability, input gaps and mid-block reset. A
// scoreboard monitor compares every output handshake against the transposed
// order.
// -----------------------------------------------------------------------------
module tb_dct_transpose_buffer;

  localparam int N = 16;

  // ---------------------------------------------------------------- clock/reset
  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_first;
  logic         out_last;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dct_transpose_buffer #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_first (out_first),
    .out_last  (out_last)
  );

  // ---------------------------------------------------------------- bookkeeping
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- scoreboard
  logic [N-1:0] exp_q[$];
  logic         mon_en = 1'b0;
  int           out_idx = 0;
  int           hs_cnt = 0;
  int           first_hs_cyc = -1;
  int           last_hs_cyc = 0;
  logic         held_v = 1'b0;
  logic [N-1:0] held_d;
  logic         held_f;
  logic         held_l;

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (held_v) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data",  32'(out_data),  32'(held_d));
        check("stall_first", 32'(out_first), 32'(held_f));
        check("stall_last",  32'(out_last),  32'(held_l));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(out_data), 32'hDEAD_BEEF);
        end else begin
          check("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
        check("sb_first", 32'(out_first), 32'(out_idx == 0));
        check("sb_last",  32'(out_last),  32'(out_idx == 63));
        out_idx = (out_idx + 1) % 64;
        hs_cnt++;
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      held_f = out_first;
      held_l = out_last;
    end else begin
      held_v = 1'b0;
    end
  end

  // ---------------------------------------------------------------- drivers
  logic [N-1:0] blk [64];
  int           stall_cnt = 0;

  // Offers blk[0..n-1] with in_valid dropped gap_pct percent of the time.
  // When a full block has gone in, the expected column-major order is queued.
  task automatic send_block(input int gap_pct, input int n);
    int   k = 0;
    int   budget = 0;
    logic acc;
    while (k < n && budget < 4000) begin
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_data  = blk[k];
      @(negedge clk);
      acc = in_valid && in_ready;
      if (in_valid && !in_ready) stall_cnt++;
      tick();
      if (acc) k++;
      budget++;
    end
    in_valid = 1'b0;
    if (k < n) check("send_timeout", 32'(k), 32'(n));
    if (n == 64) begin
      for (int m = 0; m < 64; m++) exp_q.push_back(blk[(m % 8) * 8 + m / 8]);
    end
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_hs(input int target, input int budget);
    int c = 0;
    while (hs_cnt < target && c < budget) begin
      tick();
      c++;
    end
    check("hs_timeout", 32'(hs_cnt), 32'(target));
  endtask

  task automatic do_reset;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_first", 32'(out_first), 32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    tick();
    reset = 1'b0;
    exp_q.delete();
    out_idx = 0;
    @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_in_ready",  32'(in_ready),  32'd1);
    tick();
  endtask

  // ---------------------------------------------------------------- vector table
  typedef struct {
    logic         in_valid;
    logic [N-1:0] in_data;
    logic         out_ready;
    logic         exp_in_ready;
    logic         exp_out_valid;
    logic [N-1:0] exp_out_data;
    logic         exp_first;
    logic         exp_last;
  } vec_t;

  localparam int NV = 130;
  vec_t tbl [NV];

  // Cycles 0..63 write value k = row*8+col. Output starts in cycle 64, the
  // cycle after the 64th accept. Output index m carries row m%8, column m/8,
  // i.e. value (m%8)*8 + m/8.
  task automatic build_table;
    for (int i = 0; i < NV; i++) begin
      tbl[i].in_valid      = (i < 64);
      tbl[i].in_data       = (i < 64) ? N'(i) : '0;
      tbl[i].out_ready     = 1'b1;
      tbl[i].exp_in_ready  = 1'b1;
      tbl[i].exp_out_valid = (i >= 64 && i < 128);
      tbl[i].exp_out_data  = (i >= 64 && i < 128) ? N'(((i - 64) % 8) * 8 + (i - 64) / 8) : '0;
      tbl[i].exp_first     = (i == 64);
      tbl[i].exp_last      = (i == 127);
    end
  endtask

  task automatic run_table;
    for (int i = 0; i < NV; i++) begin
      in_valid  = tbl[i].in_valid;
      in_data   = tbl[i].in_data;
      out_ready = tbl[i].out_ready;
      @(negedge clk);
      check($sformatf("tbl_in_ready[%0d]", i),  32'(in_ready),  32'(tbl[i].exp_in_ready));
      check($sformatf("tbl_out_valid[%0d]", i), 32'(out_valid), 32'(tbl[i].exp_out_valid));
      check($sformatf("tbl_out_data[%0d]", i),  32'(out_data),  32'(tbl[i].exp_out_data));
      check($sformatf("tbl_first[%0d]", i),     32'(out_first), 32'(tbl[i].exp_first));
      check($sformatf("tbl_last[%0d]", i),      32'(out_last),  32'(tbl[i].exp_last));
      tick();
    end
    in_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------- test body
  initial begin : main
    int base;
    int c;
    logic seen_last;
    logic [3:0] pat;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    build_table();
    tick();
    do_reset();

    // Single block, checked cycle by cycle.
    run_table();

    // Streaming: four back-to-back blocks with both sides always willing.
    mon_en    = 1'b1;
    out_ready = 1'b1;
    stall_cnt = 0;
    base      = hs_cnt;
    first_hs_cyc = -1;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 64; k++) blk[k] = N'(b * 64 + k);
      send_block(0, 64);
    end
    wait_drain(400);
    check("stream_in_ready_drops", 32'(stall_cnt), 32'd0);
    check("stream_hs_count", 32'(hs_cnt - base), 32'd256);
    check("stream_contiguous", 32'(last_hs_cyc - first_hs_cyc), 32'd255);

    // Backpressure: two blocks fill both banks, then the input must stall.
    out_ready = 1'b0;
    for (int k = 0; k < 64; k++) blk[k] = N'(16'h1000 + k);
    send_block(0, 64);
    for (int k = 0; k < 64; k++) blk[k] = N'(16'h2000 + k);
    send_block(0, 64);
    in_valid = 1'b1;
    in_data  = 16'hBAD0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    seen_last = 1'b0;
    c = 0;
    while (!seen_last && c < 200) begin
      @(negedge clk);
      if (out_valid && out_last) begin
        seen_last = 1'b1;
        check("bp_in_ready_before_free", 32'(in_ready), 32'd0);
      end
      tick();
      c++;
    end
    check("bp_last_seen", 32'(seen_last), 32'd1);
    @(negedge clk);
    check("bp_in_ready_after_free", 32'(in_ready), 32'd1);
    tick();
    wait_drain(200);

    // Stall stability: out_ready pattern 1,0,0,1 during a drain.
    out_ready = 1'b0;
    for (int k = 0; k < 64; k++) blk[k] = N'(16'h3000 + k * 3);
    send_block(0, 64);
    base = hs_cnt;
    pat  = 4'b1001;
    c    = 0;
    while (hs_cnt < base + 64 && c < 400) begin
      out_ready = pat[c % 4];
      tick();
      c++;
    end
    out_ready = 1'b1;
    check("stall_hs_count", 32'(hs_cnt - base), 32'd64);
    check("stall_queue_empty", 32'(exp_q.size()), 32'd0);

    // Input gaps with signed corner values.
    out_ready = 1'b1;
    for (int k = 0; k < 64; k++) blk[k] = N'($urandom_range(0, 65535));
    blk[0]  = 16'h8000;
    blk[7]  = 16'h7FFF;
    blk[56] = 16'hFFFF;
    send_block(50, 64);
    check("gap_exp_idx0",  32'(exp_q[0]),  32'h8000);
    check("gap_exp_idx7",  32'(exp_q[7]),  32'hFFFF);
    check("gap_exp_idx56", 32'(exp_q[56]), 32'h7FFF);
    wait_drain(200);

    // Mid-operation reset: block 0 drained to index 20, block 1 has 30 writes.
    out_ready = 1'b0;
    for (int k = 0; k < 64; k++) blk[k] = N'(16'h4000 + k);
    send_block(0, 64);
    base = hs_cnt;
    out_ready = 1'b1;
    wait_hs(base + 20, 100);
    out_ready = 1'b0;
    for (int k = 0; k < 64; k++) blk[k] = N'(16'h5000 + k);
    send_block(0, 30);
    @(negedge clk);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    tick();
    mon_en = 1'b0;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("after_rst_no_output", 32'(out_valid), 32'd0);
      tick();
    end
    run_table();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
